// File: rtl/slv_guard_rst_seq.sv
// ---------------------------------------------------------------------------
// slv_guard_rst_seq
//   Reset sequencer for an AXI subordinate behind a write guard. On a guard
//   request it isolates the port, waits for quiescence (or gives up after
//   IsoTimeout cycles), holds the subordinate reset request for at least
//   HoldCycles, waits for the subordinate to leave reset, then removes
//   isolation and raises a completion interrupt.
//
//   Optional feature macro: SLV_GUARD_RST_CNT_EN compiles in the saturating
//   completed-sequence counter. Without it rst_cnt_o is tied to zero.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            synchronous active-high reset
//   guard_rst_req_i  reset request from write guard (level or pulse)
//   isolate_o        ask isolation stage to block new AW/AR and drain
//   isolated_i       isolation stage reports the port quiescent
//   rst_req_o        reset request to subordinate reset controller
//   rst_stat_i       1 while the subordinate is held in reset
//   busy_o           sequencer not idle
//   iso_timeout_o    sticky: isolation timed out
//   irq_o            sticky: a sequence completed
//   irq_clr_i        clears irq_o and iso_timeout_o (a same-cycle set wins)
//   rst_cnt_o        completed sequence count (saturating)
// ---------------------------------------------------------------------------
module slv_guard_rst_seq #(
    parameter int IsoTimeout = 64,
    parameter int HoldCycles = 8,
    parameter int CntWidth   = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                guard_rst_req_i,
    output logic                isolate_o,
    input  logic                isolated_i,
    output logic                rst_req_o,
    input  logic                rst_stat_i,
    output logic                busy_o,
    output logic                iso_timeout_o,
    output logic                irq_o,
    input  logic                irq_clr_i,
    output logic [CntWidth-1:0] rst_cnt_o
);

    localparam int TMax = (IsoTimeout > HoldCycles) ? IsoTimeout : HoldCycles;
    localparam int TW   = $clog2(TMax) + 1;
    localparam logic [TW-1:0] ISO_LAST  = TW'(IsoTimeout - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HoldCycles - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISOLATE  = 3'd1,
        S_RESET    = 3'd2,
        S_WAIT_REL = 3'd3,
        S_UNISO    = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic          r_pending, w_pending_nxt;
    logic          r_iso_to, r_irq;
    logic          w_take_pend;   // a request (new or pending) starts ISOLATE
    logic          w_set_to;      // isolation gave up without an ack
    logic          w_done;        // UNISO exit: one sequence completed

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / timer / pending
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_take_pend = 1'b0;
        w_set_to    = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_timer_nxt = '0;
                if (guard_rst_req_i || r_pending) begin
                    w_state_nxt = S_ISOLATE;
                    w_take_pend = 1'b1;
                end
            end
            S_ISOLATE: begin
                if (isolated_i || (r_timer == ISO_LAST)) begin
                    w_state_nxt = S_RESET;
                    w_timer_nxt = '0;
                    w_set_to    = ~isolated_i;
                end else begin
                    // strictly below ISO_LAST here, so no wrap
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_RESET: begin
                if ((r_timer == HOLD_LAST) && rst_stat_i) begin
                    w_state_nxt = S_WAIT_REL;
                    w_timer_nxt = '0;
                end else if (r_timer != HOLD_LAST) begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            S_WAIT_REL: begin
                w_timer_nxt = '0;
                if (!rst_stat_i) w_state_nxt = S_UNISO;
            end
            S_UNISO: begin
                w_timer_nxt = '0;
                if (!isolated_i) begin
                    w_done = 1'b1;
                    // back-to-back sequence skips IDLE entirely
                    if (r_pending) begin
                        w_state_nxt = S_ISOLATE;
                        w_take_pend = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
            end
        endcase

        if (w_take_pend)
            w_pending_nxt = 1'b0;
        else if (guard_rst_req_i && (r_state != S_IDLE))
            w_pending_nxt = 1'b1;
        else
            w_pending_nxt = r_pending;
    end

    // ------------------------------------------------------------------
    // Sticky flags: set has priority over clear
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_iso_to <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_set_to)       r_iso_to <= 1'b1;
            else if (irq_clr_i) r_iso_to <= 1'b0;
            if (w_done)         r_irq    <= 1'b1;
            else if (irq_clr_i) r_irq    <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Completed-sequence counter
    // ------------------------------------------------------------------
`ifdef SLV_GUARD_RST_CNT_EN
    logic [CntWidth-1:0] r_cnt;
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_cnt <= '0;
        else if (w_done && (r_cnt != {CntWidth{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end
    assign rst_cnt_o = r_cnt;
`else
    assign rst_cnt_o = '0;
`endif

    // ------------------------------------------------------------------
    // Moore outputs, decoded only from registers
    // ------------------------------------------------------------------
    assign busy_o        = (r_state != S_IDLE);
    assign rst_req_o     = (r_state == S_RESET);
    assign isolate_o     = (r_state == S_ISOLATE) || (r_state == S_RESET) ||
                           (r_state == S_WAIT_REL);
    assign iso_timeout_o = r_iso_to;
    assign irq_o         = r_irq;

endmodule
